ren_conv_sched: RTL

//  Job scheduler for the pool of ren_conv_top convolution engines. Accepts jobs from the host-side

---
 rtl/ren_sched_pkg.sv | 18 +
 rtl/ren_rr_arbiter.sv | 31 +++
 rtl/ren_conv_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ren_sched_pkg.sv
// rtl/ren_sched_pkg.sv - shared engine state type, default sizes and round-robin pointer helper
package ren_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } eng_state_e;

    localparam int N_ENG_DEF = 11;
    localparam int TAG_W_DEF = 8;

    function automatic int rr_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ren_rr_arbiter.sv
// rtl/ren_rr_arbiter.sv - round-robin arbiter: first requester at or after ptr wins
module ren_rr_arbiter
    import ren_sched_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        int v_c;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        v_c     = (int'(i_ptr) < N) ? int'(i_ptr) : 0;
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_req[v_c]) begin
                o_any        = 1'b1;
                o_grant[v_c] = 1'b1;
                o_idx        = W'(v_c);
            end
            v_c = rr_inc(v_c, N);
        end
    end

endmodule

// File: rtl/ren_conv_sched.sv
// rtl/ren_conv_sched.sv - round-robin job scheduler for the ren_conv engine pool
// Optional watchdog: define REN_SCHED_TIMEOUT_EN.
module ren_conv_sched
    import ren_sched_pkg::*;
#(
    parameter  int N_ENG       = N_ENG_DEF,
    parameter  int TAG_W       = TAG_W_DEF,
    parameter  int RST_CYCLES  = 2,
    parameter  int TIMEOUT_CYC = 65535,
    localparam int ENG_W       = $clog2(N_ENG)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [N_ENG-1:0] eng_en_i,
    input  logic             job_valid_i,
    input  logic [TAG_W-1:0] job_tag_i,
    output logic             job_ready_o,
    output logic [N_ENG-1:0] eng_rst_o,
    output logic [N_ENG-1:0] eng_start_o,
    input  logic [N_ENG-1:0] eng_done_i,
    output logic [N_ENG-1:0] busy_o,
    output logic             cmp_valid_o,
    input  logic             cmp_ready_i,
    output logic [ENG_W-1:0] cmp_eng_o,
    output logic [TAG_W-1:0] cmp_tag_o,
    output logic             cmp_err_o,
    output logic             irq_o
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);

    if (N_ENG < 2 || RST_CYCLES < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("ren_conv_sched: illegal parameter set");
    end

    eng_state_e       r_state     [N_ENG];
    eng_state_e       w_state_nxt [N_ENG];
    logic [RC_W-1:0]  r_rcnt      [N_ENG];
    logic [RC_W-1:0]  w_rcnt_nxt  [N_ENG];
    logic [TAG_W-1:0] r_tag       [N_ENG];
    logic [N_ENG-1:0] r_start;
    logic [N_ENG-1:0] w_start_nxt;
    logic [N_ENG-1:0] w_idle;
    logic [N_ENG-1:0] w_done;

    logic [ENG_W-1:0] r_dptr;
    logic [ENG_W-1:0] r_cptr;
    logic [N_ENG-1:0] w_dgrant;
    logic [N_ENG-1:0] w_cgrant;
    logic [ENG_W-1:0] w_didx;
    logic [ENG_W-1:0] w_cidx;
    logic             w_dany;
    logic             w_cany;
    logic [TAG_W-1:0] w_ctag;

    logic             r_cmp_valid;
    logic [ENG_W-1:0] r_cmp_eng;
    logic [TAG_W-1:0] r_cmp_tag;
    logic             r_irq;

    logic             w_accept;
    logic             w_cmp_hs;
    logic             w_cmp_load;

`ifdef REN_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]  r_tcnt     [N_ENG];
    logic [TO_W-1:0]  w_tcnt_nxt [N_ENG];
    logic [N_ENG-1:0] r_err;
    logic [N_ENG-1:0] w_err_nxt;
    logic             r_cmp_err;
`endif

    always_comb begin
        w_idle = '0;
        w_done = '0;
        for (int k = 0; k < N_ENG; k++) begin
            w_idle[k] = (r_state[k] == IDLE);
            w_done[k] = (r_state[k] == DONE);
        end
    end

    ren_rr_arbiter #(.N(N_ENG)) u_disp_arb (
        .i_req   (w_idle & eng_en_i),
        .i_ptr   (r_dptr),
        .o_grant (w_dgrant),
        .o_idx   (w_didx),
        .o_any   (w_dany)
    );

    // Only arbitrate completions while the output slot is empty, so a held record never changes.
    ren_rr_arbiter #(.N(N_ENG)) u_cmp_arb (
        .i_req   (w_done),
        .i_ptr   (r_cptr),
        .o_grant (w_cgrant),
        .o_idx   (w_cidx),
        .o_any   (w_cany)
    );

    assign w_accept   = job_valid_i && w_dany;
    assign w_cmp_hs   = r_cmp_valid && cmp_ready_i;
    assign w_cmp_load = !r_cmp_valid && w_cany;

    always_comb begin
        w_ctag = '0;
        for (int k = 0; k < N_ENG; k++) begin
            if (w_cgrant[k]) begin
                w_ctag = w_ctag | r_tag[k];
            end
        end
    end

    always_comb begin
        w_start_nxt = '0;
`ifdef REN_SCHED_TIMEOUT_EN
        w_err_nxt = r_err;
`endif
        for (int k = 0; k < N_ENG; k++) begin
            w_state_nxt[k] = r_state[k];
            w_rcnt_nxt[k]  = r_rcnt[k];
`ifdef REN_SCHED_TIMEOUT_EN
            w_tcnt_nxt[k]  = r_tcnt[k];
`endif
            case (r_state[k])
                IDLE: begin
                    if (w_accept && w_dgrant[k]) begin
                        w_state_nxt[k] = RESET;
                        w_rcnt_nxt[k]  = RC_W'(RST_CYCLES - 1);
                    end
                end
                RESET: begin
                    if (r_rcnt[k] == '0) begin
                        w_state_nxt[k] = RUN;
                        w_start_nxt[k] = 1'b1;
`ifdef REN_SCHED_TIMEOUT_EN
                        w_tcnt_nxt[k]  = '0;
`endif
                    end else begin
                        w_rcnt_nxt[k] = r_rcnt[k] - 1'b1;
                    end
                end
                RUN: begin
                    // done is not trusted during the start cycle; the engine was just released
                    if (!r_start[k] && eng_done_i[k]) begin
                        w_state_nxt[k] = DONE;
`ifdef REN_SCHED_TIMEOUT_EN
                        w_err_nxt[k]   = 1'b0;
                    end else if (r_tcnt[k] == TO_W'(TIMEOUT_CYC - 1)) begin
                        w_state_nxt[k] = DONE;
                        w_err_nxt[k]   = 1'b1;
                    end else begin
                        w_tcnt_nxt[k]  = r_tcnt[k] + 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (w_cmp_hs && r_cmp_eng == ENG_W'(k)) begin
                        w_state_nxt[k] = IDLE;
                    end
                end
                default: w_state_nxt[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            for (int k = 0; k < N_ENG; k++) begin
                r_state[k] <= IDLE;
                r_rcnt[k]  <= '0;
            end
            r_start <= '0;
        end else begin
            for (int k = 0; k < N_ENG; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_rcnt[k]  <= w_rcnt_nxt[k];
            end
            r_start <= w_start_nxt;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            for (int k = 0; k < N_ENG; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_ENG; k++) begin
                if (w_accept && w_dgrant[k]) begin
                    r_tag[k] <= job_tag_i;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_dptr      <= '0;
            r_cptr      <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_eng   <= '0;
            r_cmp_tag   <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= r_cmp_valid;
            if (w_accept) begin
                r_dptr <= ENG_W'(rr_inc(int'(w_didx), N_ENG));
            end
            if (w_cmp_hs) begin
                r_cmp_valid <= 1'b0;
                r_cptr      <= ENG_W'(rr_inc(int'(r_cmp_eng), N_ENG));
            end else if (w_cmp_load) begin
                r_cmp_valid <= 1'b1;
                r_cmp_eng   <= w_cidx;
                r_cmp_tag   <= w_ctag;
            end
        end
    end

`ifdef REN_SCHED_TIMEOUT_EN
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            for (int k = 0; k < N_ENG; k++) begin
                r_tcnt[k] <= '0;
            end
            r_err     <= '0;
            r_cmp_err <= 1'b0;
        end else begin
            for (int k = 0; k < N_ENG; k++) begin
                r_tcnt[k] <= w_tcnt_nxt[k];
            end
            r_err <= w_err_nxt;
            if (w_cmp_hs) begin
                r_cmp_err <= 1'b0;
            end else if (w_cmp_load) begin
                r_cmp_err <= |(w_cgrant & r_err);
            end
        end
    end

    assign cmp_err_o = r_cmp_err;
`else
    assign cmp_err_o = 1'b0;
`endif

    always_comb begin
        eng_rst_o = '0;
        for (int k = 0; k < N_ENG; k++) begin
            eng_rst_o[k] = (r_state[k] == IDLE) || (r_state[k] == RESET);
        end
    end

    assign job_ready_o = w_dany;
    assign eng_start_o = r_start;
    assign busy_o      = ~w_idle;
    assign cmp_valid_o = r_cmp_valid;
    assign cmp_eng_o   = r_cmp_eng;
    assign cmp_tag_o   = r_cmp_tag;
    assign irq_o       = r_irq;

endmodule
